// File: rtl/usb_line_tx.sv
// USB bit-level line transmitter: SYNC, NRZI with bit stuffing, EOP and bus output enable.
// Optional abort sequence (txAbort input) enabled by defining USB_LINE_TX_ABORT_EN.
module usb_line_tx #(
  parameter int CLK_DIV   = 4,
  parameter bit LOW_SPEED = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef USB_LINE_TX_ABORT_EN
  input  logic       txAbort,
`endif
  input  logic [7:0] txByte,
  input  logic       txByteValid,
  input  logic       txByteLast,
  output logic       txByteReady,
  output logic [1:0] txDataOut,
  output logic       txOE,
  output logic       txBusy,
  output logic       txUnderrun
);

  localparam int              CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [1:0]      LINE_J   = LOW_SPEED ? 2'b01 : 2'b10;
  localparam logic [1:0]      LINE_K   = LOW_SPEED ? 2'b10 : 2'b01;
  localparam logic [1:0]      LINE_SE0 = 2'b00;
  localparam logic [7:0]      SYNC_PAT = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    ABORT,
    EOP_SE0,
    EOP_J
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [6:0]       shift;
  logic [7:0]       hold;
  logic [2:0]       bit_idx;
  logic [2:0]       ones;
  logic             stuffing;
  logic             cur_last;
  logic             hold_valid;
  logic             hold_last;
  logic             eop_bit;

`ifdef USB_LINE_TX_ABORT_EN
  logic             abort_req;
  logic [2:0]       abort_cnt;
  logic             go_abort;
`endif

  logic             bit_end;
  logic             accept;
  logic             need_stuff;
  logic             byte_end;
  logic             load;
  logic             next_bit;

  // NRZI: a zero toggles the line, a one holds it.
  function automatic logic [1:0] nrzi(input logic [1:0] cur, input logic b);
    return b ? cur : ~cur;
  endfunction

  assign bit_end     = (cnt == CNT_MAX);
  assign txByteReady = !hold_valid && (state != EOP_SE0) && (state != EOP_J) && (state != ABORT);
  assign accept      = txByteValid && txByteReady;
  assign need_stuff  = !stuffing && (ones == 3'd6);
  assign next_bit    = shift[0];
  assign byte_end    = ((state == SYNC) || (state == DATA)) && bit_end && !need_stuff &&
                       (bit_idx == 3'd7);

`ifdef USB_LINE_TX_ABORT_EN
  assign go_abort = abort_req || txAbort;
  assign load     = byte_end && !cur_last && hold_valid && !go_abort;
`else
  assign load     = byte_end && !cur_last && hold_valid;
`endif

  // shift holds the bits still to come after the one currently on the line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      hold       <= '0;
      bit_idx    <= '0;
      ones       <= '0;
      stuffing   <= 1'b0;
      cur_last   <= 1'b0;
      hold_valid <= 1'b0;
      hold_last  <= 1'b0;
      eop_bit    <= 1'b0;
      txDataOut  <= LINE_J;
      txOE       <= 1'b0;
      txBusy     <= 1'b0;
      txUnderrun <= 1'b0;
`ifdef USB_LINE_TX_ABORT_EN
      abort_req  <= 1'b0;
      abort_cnt  <= '0;
`endif
    end else begin
      txUnderrun <= 1'b0;

      if ((state == IDLE) || bit_end) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (accept) begin
        hold       <= txByte;
        hold_last  <= txByteLast;
        hold_valid <= 1'b1;
      end else if (load) begin
        hold_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (hold_valid || accept) begin
            state     <= SYNC;
            txOE      <= 1'b1;
            txBusy    <= 1'b1;
            txDataOut <= LINE_K;
            shift     <= SYNC_PAT[7:1];
            bit_idx   <= '0;
            ones      <= '0;
            stuffing  <= 1'b0;
            cur_last  <= 1'b0;
`ifdef USB_LINE_TX_ABORT_EN
            abort_req <= 1'b0;
`endif
          end
        end

        SYNC, DATA: begin
`ifdef USB_LINE_TX_ABORT_EN
          if (txAbort) begin
            abort_req <= 1'b1;
          end
`endif
          if (bit_end) begin
`ifdef USB_LINE_TX_ABORT_EN
            if (go_abort) begin
              state      <= ABORT;
              abort_cnt  <= '0;
              abort_req  <= 1'b0;
              stuffing   <= 1'b0;
              hold_valid <= 1'b0;
            end else
`endif
            if (need_stuff) begin
              stuffing  <= 1'b1;
              ones      <= '0;
              txDataOut <= ~txDataOut;
            end else if (bit_idx != 3'd7) begin
              stuffing  <= 1'b0;
              bit_idx   <= bit_idx + 3'd1;
              shift     <= shift >> 1;
              txDataOut <= nrzi(txDataOut, next_bit);
              ones      <= next_bit ? ones + 3'd1 : 3'd0;
            end else if (cur_last) begin
              stuffing  <= 1'b0;
              state     <= EOP_SE0;
              eop_bit   <= 1'b0;
              txDataOut <= LINE_SE0;
            end else if (hold_valid) begin
              // The ones run carries across byte boundaries (SYNC's final 1 included).
              stuffing  <= 1'b0;
              state     <= DATA;
              shift     <= hold[7:1];
              bit_idx   <= '0;
              cur_last  <= hold_last;
              txDataOut <= nrzi(txDataOut, hold[0]);
              ones      <= hold[0] ? ones + 3'd1 : 3'd0;
            end else begin
              txUnderrun <= 1'b1;
              stuffing   <= 1'b0;
`ifdef USB_LINE_TX_ABORT_EN
              state      <= ABORT;
              abort_cnt  <= '0;
              abort_req  <= 1'b0;
`else
              state      <= EOP_SE0;
              eop_bit    <= 1'b0;
              txDataOut  <= LINE_SE0;
`endif
            end
          end
        end

`ifdef USB_LINE_TX_ABORT_EN
        ABORT: begin
          // Seven unstuffed ones: the line simply holds its level.
          if (bit_end) begin
            if (abort_cnt == 3'd6) begin
              state     <= EOP_SE0;
              eop_bit   <= 1'b0;
              txDataOut <= LINE_SE0;
            end else begin
              abort_cnt <= abort_cnt + 3'd1;
            end
          end
        end
`endif

        EOP_SE0: begin
          if (bit_end) begin
            if (eop_bit) begin
              state     <= EOP_J;
              txDataOut <= LINE_J;
            end else begin
              eop_bit <= 1'b1;
            end
          end
        end

        EOP_J: begin
          if (bit_end) begin
            state  <= IDLE;
            txOE   <= 1'b0;
            txBusy <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
